// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Busy-cycle counter for the memory port arbiter.
// Cleared when an access is accepted, counts every busy cycle, and flags
// expiry in the cycle whose count equals TIMEOUT-1. TIMEOUT=0 never expires.
module arb_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] count;

    // busy-cycle count, restarted on every accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_never
            assign expire = 1'b0;
        end else begin : g_cmp
            assign expire = en && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One access in flight at a time; data wins ties unless MEM_ARB_RR_EN is
// defined, in which case ties alternate (first tie after reset goes to fetch).
// An access that sees no mem_ack for TIMEOUT busy cycles is aborted with err.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          err,
    output logic          pc_stall
);
    state_t  state, state_nxt;
    req_id_t sel, tie_winner;
    logic    accept, done_ack, done_abort, busy, expire;

    assign busy     = (state != IDLE);
    assign pc_stall = ~((~d_req | d_valid) & (~if_req | if_valid));

`ifdef MEM_ARB_RR_EN
    req_id_t last_gnt;

    // remember who won the most recent accept so ties can alternate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= REQ_D;
        end else if (accept) begin
            last_gnt <= sel;
        end
    end

    assign tie_winner = (last_gnt == REQ_D) ? REQ_IF : REQ_D;
`else
    assign tie_winner = REQ_D;
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state, arbitration and completion decode
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        sel        = REQ_D;
        done_ack   = 1'b0;
        done_abort = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    accept = 1'b1;
                    if (if_req && d_req) begin
                        sel = tie_winner;
                    end else if (d_req) begin
                        sel = REQ_D;
                    end else begin
                        sel = REQ_IF;
                    end
                    state_nxt = (sel == REQ_D) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                // an ack in the expiry cycle still completes normally
                if (mem_ack) begin
                    done_ack  = 1'b1;
                    state_nxt = IDLE;
                end else if (expire) begin
                    done_abort = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // memory-side request registers, grant/valid pulses and read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_gnt   <= 1'b0;
            d_gnt    <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            err      <= 1'b0;
            if (accept) begin
                mem_req   <= 1'b1;
                mem_we    <= (sel == REQ_D) && d_we;
                mem_addr  <= (sel == REQ_D) ? d_addr : if_addr;
                mem_wdata <= (sel == REQ_D) ? d_wdata : '0;
                if_gnt    <= (sel == REQ_IF);
                d_gnt     <= (sel == REQ_D);
            end
            if (done_ack) begin
                mem_req <= 1'b0;
                if (state == BUSY_I) begin
                    if_valid <= 1'b1;
                    if_rdata <= mem_rdata;
                end else begin
                    d_valid <= 1'b1;
                    if (!mem_we) begin
                        d_rdata <= mem_rdata;
                    end
                end
            end
            if (done_abort) begin
                mem_req <= 1'b0;
                err     <= 1'b1;
                if (state == BUSY_I) begin
                    if_valid <= 1'b1;
                    if_rdata <= DW'(ABORT_DATA);
                end else begin
                    d_valid <= 1'b1;
                    d_rdata <= DW'(ABORT_DATA);
                end
            end
        end
    end

    arb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (busy),
        .expire (expire)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (default parameters).
// Expected completions are queued when a request is driven and popped by a
// monitor when if_valid/d_valid pulses. Memory model answers with
// mem_addr ^ 32'h1274 after a programmable number of busy cycles.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_valid, d_gnt, d_valid;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_req, mem_we, mem_ack, err, pc_stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err(err), .pc_stall(pc_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        req_id_t     src;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cycles;
    } vec_t;

    exp_t    sb[$];
    int      checks = 0;
    int      errors = 0;
    int      mem_lat = 0;
    logic    stray_ack = 1'b0;
    req_id_t bench_last = REQ_D;

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return a ^ 32'h0000_1274;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_wait(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out waiting (actual=none expected=event)", name);
    endtask

    task automatic check_zero(input string tag);
        check($sformatf("%s.flags", tag),
              {56'd0, if_gnt, if_valid, d_gnt, d_valid, mem_req, mem_we, err, pc_stall}, 64'd0);
        check($sformatf("%s.if_rdata", tag), {32'd0, if_rdata}, 64'd0);
        check($sformatf("%s.d_rdata", tag), {32'd0, d_rdata}, 64'd0);
        check($sformatf("%s.mem_addr", tag), {32'd0, mem_addr}, 64'd0);
        check($sformatf("%s.mem_wdata", tag), {32'd0, mem_wdata}, 64'd0);
    endtask

    // memory model: ack on the mem_lat-th busy cycle (mem_lat<=0 never acks)
    initial begin
        int  mcnt;
        bit  acked;
        mcnt = 0;
        acked = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = stray_ack;
            mem_rdata = 32'h0BAD_0BAD;
            if (mem_req && !acked) begin
                mcnt++;
                if (mem_lat > 0 && mcnt == mem_lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = exp_rd(mem_addr);
                    acked = 1;
                end
            end else if (!mem_req) begin
                mcnt = 0;
                acked = 0;
            end
        end
    end

    // completion monitor: pops the scoreboard on every valid pulse
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (if_valid || d_valid)) begin
            check("valid_onehot", {63'd0, if_valid & d_valid}, 64'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=if%0b/d%0b expected=no completion", if_valid, d_valid);
            end else begin
                e = sb.pop_front();
                check("valid_src", {63'd0, d_valid}, {63'd0, e.src == REQ_D});
                check("rdata", {32'd0, (d_valid ? d_rdata : if_rdata)}, {32'd0, e.rdata});
                check("err", {63'd0, err}, {63'd0, e.err});
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        int   cyc;
        bit   got;
        mem_lat = v.lat;
        e.src = v.is_d ? REQ_D : REQ_IF;
        e.rdata = v.exp_rdata;
        e.err = v.exp_err;
        sb.push_back(e);
        bench_last = e.src;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (v.is_d ? d_gnt : if_gnt) got = 1;
        end
        d_req = 1'b0;
        if_req = 1'b0;
        if (!got) begin
            fail_wait($sformatf("%s.gnt", tag));
            void'(sb.pop_back());
            return;
        end
        check($sformatf("%s.other_gnt", tag), {63'd0, v.is_d ? if_gnt : d_gnt}, 64'd0);
        check($sformatf("%s.mem_req", tag), {63'd0, mem_req}, 64'd1);
        check($sformatf("%s.mem_addr", tag), {32'd0, mem_addr}, {32'd0, v.addr});
        check($sformatf("%s.mem_we", tag), {63'd0, mem_we}, {63'd0, v.is_d & v.we});
        if (v.is_d && v.we)
            check($sformatf("%s.mem_wdata", tag), {32'd0, mem_wdata}, {32'd0, v.wdata});
        got = 0;
        cyc = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (if_valid || d_valid) got = 1;
        end
        if (!got) begin
            fail_wait($sformatf("%s.valid", tag));
        end else begin
            check($sformatf("%s.latency", tag), 64'(cyc), 64'(v.exp_cycles));
            check($sformatf("%s.mem_req_low", tag), {63'd0, mem_req}, 64'd0);
        end
        @(negedge clk);
    endtask

    task automatic run_tie(input logic [31:0] da, input logic [31:0] ia, input string tag);
        req_id_t first, second;
        req_id_t order[2];
        int      ng, nv;
        exp_t    e;
`ifdef MEM_ARB_RR_EN
        first = (bench_last == REQ_D) ? REQ_IF : REQ_D;
`else
        first = REQ_D;
`endif
        second = (first == REQ_D) ? REQ_IF : REQ_D;
        e.err = 1'b0;
        e.src = first;  e.rdata = exp_rd(first == REQ_D ? da : ia);  sb.push_back(e);
        e.src = second; e.rdata = exp_rd(second == REQ_D ? da : ia); sb.push_back(e);
        bench_last = second;
        order[0] = second;
        order[1] = first;
        mem_lat = 2;
        d_req = 1'b1; d_we = 1'b0; d_addr = da;
        if_req = 1'b1; if_addr = ia;
        ng = 0;
        nv = 0;
        for (int i = 0; i < 40 && nv < 2; i++) begin
            @(negedge clk);
            check($sformatf("%s.stall", tag), {63'd0, pc_stall}, {63'd0, d_req | if_req});
            check($sformatf("%s.gnt_onehot", tag), {63'd0, d_gnt & if_gnt}, 64'd0);
            if (d_gnt) begin
                if (ng < 2) order[ng] = REQ_D;
                ng++;
                d_req = 1'b0;
            end
            if (if_gnt) begin
                if (ng < 2) order[ng] = REQ_IF;
                ng++;
                if_req = 1'b0;
            end
            if (if_valid || d_valid) nv++;
        end
        d_req = 1'b0;
        if_req = 1'b0;
        if (nv < 2) fail_wait($sformatf("%s.valids", tag));
        check($sformatf("%s.num_gnt", tag), 64'(ng), 64'd2);
        check($sformatf("%s.first", tag), {63'd0, order[0]}, {63'd0, first});
        check($sformatf("%s.second", tag), {63'd0, order[1]}, {63'd0, second});
        check($sformatf("%s.stall_end", tag), {63'd0, pc_stall}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        bit   got;
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         3,  32'h0000_1234, 1'b0, 3};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0044, 32'h0000_CAFE, 1,  32'h0000_1234, 1'b0, 1};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,         1,  32'h0000_1074, 1'b0, 1};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0,         16, 32'h0000_1174, 1'b0, 16};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0400, 32'h0,         -1, 32'hDEAD_BEEF, 1'b1, 16};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         5,  32'h0000_0274, 1'b0, 5};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_2000, 32'h5555_AAAA, 17, 32'hDEAD_BEEF, 1'b1, 16};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         2,  32'h0000_127C, 1'b0, 2};
        vecs[8] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4,  32'hFFFF_ED88, 1'b0, 4};

        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_tie(32'h0000_0080, 32'h0000_0100, "tie1");
        run_tie(32'h0000_0084, 32'h0000_0104, "tie2");

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        run_tie(32'h0000_0088, 32'h0000_0108, "tie3");

        // stray ack while idle must not complete anything
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("idle_ack", {60'd0, mem_req, if_valid, d_valid, err}, 64'd0);
            @(negedge clk);
        end

        // reset in the middle of a data access
        mem_lat = -1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0060;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (d_gnt) got = 1;
        end
        d_req = 1'b0;
        if (!got) fail_wait("midrst.gnt");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        bench_last = REQ_D;
        @(negedge clk);
        run_vec(vecs[0], "post_rst");

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
